uart_rx_fifo: RTL and testbench

//  Parametrised UART receiver: runtime baud divisor; 5..9 data bits; none/odd/even parity; 1 or 2 stop bits.
//  Per-word parity/framing error flags; false-start and glitch rejection; output FIFO with valid/ready handshake.

---
 rtl/uart_rx_fifo.sv | 201 ++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver with oversampled majority voting, parity/framing checks and
// a first-word-fall-through output FIFO carrying {frame_err, parity_err, data}.
module uart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DIV_W-1:0]              baud_div,
    input  logic                          rxd,
    output logic [DATA_BITS-1:0]          m_data,
    output logic                          m_parity_err,
    output logic                          m_frame_err,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          overrun,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int BC_W  = $clog2(DATA_BITS + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int WRD_W = DATA_BITS + 2;
    localparam logic [OS_W-1:0] VOTE_LO  = OS_W'(OVERSAMPLE/2 - 1);
    localparam logic [OS_W-1:0] VOTE_MID = OS_W'(OVERSAMPLE/2);
    localparam logic [OS_W-1:0] VOTE_HI  = OS_W'(OVERSAMPLE/2 + 1);
    localparam logic [OS_W-1:0] BIT_END  = OS_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_e;

    logic                 rxd_meta_q, rxd_sync_q;
    logic [DIV_W-1:0]     div_cnt_q;
    logic                 tick;
    logic                 armed_q;
    state_e               state_q, state_d;
    logic [OS_W-1:0]      os_cnt_q, os_cnt_d;
    logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [1:0]           smp_q, smp_d;
    logic                 perr_q, perr_d, ferr_q, ferr_d;
    logic                 vote, at_vote, at_end;
    logic                 push;
    logic [WRD_W-1:0]     push_word;

    // Two-flop synchroniser; idles high so reset looks like a quiet line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
        end else begin
            rxd_meta_q <= rxd;
            rxd_sync_q <= rxd_meta_q;
        end
    end

    // >= keeps the divider from running away if baud_div shrinks mid-count
    assign tick = (div_cnt_q >= baud_div);

    // Free-running oversample tick divider
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       div_cnt_q <= '0;
        else if (tick) div_cnt_q <= '0;
        else           div_cnt_q <= div_cnt_q + 1'b1;
    end

    // Arm start detection only after the line has been seen idle-high
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     armed_q <= 1'b0;
        else if (tick && rxd_sync_q) armed_q <= 1'b1;
    end

    // Majority of the two stored samples and the current one at the vote point
    assign vote    = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxd_sync_q) | (smp_q[1] & rxd_sync_q);
    assign at_vote = (os_cnt_q == VOTE_HI);
    assign at_end  = (os_cnt_q == BIT_END);
    // The last stop bit's own vote is folded in because push happens on that tick
    assign push_word = {ferr_q | ~vote, perr_q, shreg_q};

    // Receive FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            os_cnt_q  <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            smp_q     <= 2'b11;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            os_cnt_q  <= os_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            smp_q     <= smp_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    // Receive FSM next state: everything advances on oversample ticks only
    always_comb begin
        state_d   = state_q;
        os_cnt_d  = os_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        smp_d     = smp_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        push      = 1'b0;
        if (tick) begin
            if (state_q != S_IDLE) begin
                os_cnt_d = os_cnt_q + 1'b1;
                if (os_cnt_q == VOTE_LO)  smp_d[0] = rxd_sync_q;
                if (os_cnt_q == VOTE_MID) smp_d[1] = rxd_sync_q;
            end
            case (state_q)
                S_IDLE: begin
                    if (armed_q && !rxd_sync_q) begin
                        state_d   = S_START;
                        os_cnt_d  = '0;
                        bit_cnt_d = '0;
                        perr_d    = 1'b0;
                        ferr_d    = 1'b0;
                    end
                end
                S_START: begin
                    if (at_vote && vote) state_d = S_IDLE;
                    else if (at_end)     state_d = S_DATA;
                end
                S_DATA: begin
                    if (at_vote) shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
                    if (at_end) begin
                        if (bit_cnt_q == BC_W'(DATA_BITS - 1)) begin
                            bit_cnt_d = '0;
                            state_d   = (PARITY != 0) ? S_PAR : S_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
                S_PAR: begin
                    if (at_vote) perr_d = ((^shreg_q) ^ vote) != (PARITY == 1);
                    if (at_end)  state_d = S_STOP;
                end
                S_STOP: begin
                    if (at_vote) begin
                        if (!vote) ferr_d = 1'b1;
                        if (bit_cnt_q == BC_W'(STOP_BITS - 1)) begin
                            push    = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else if (at_end) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign busy = (state_q != S_IDLE);

    // ---------------- output FIFO ----------------
    logic [WRD_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             full, pop, wr_en;

    assign full    = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    assign pop     = (count_q != '0) && m_ready;
    // A pop on the same clock frees the slot the write lands in
    assign wr_en   = push && (!full || pop);
    assign overrun = push && full && !pop;

    // Storage and pointers; storage cleared so outputs read 0 out of reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= push_word;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (wr_en && !pop)      count_q <= count_q + 1'b1;
            else if (!wr_en && pop) count_q <= count_q - 1'b1;
        end
    end

    assign {m_frame_err, m_parity_err, m_data} = mem_q[rd_ptr_q];
    assign m_valid    = (count_q != '0);
    assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench: three receiver configurations (8N1 and 8E1 at 64 clk/bit,
// 9N2 at 16 clk/bit) driven from one linear stimulus sequence.
module tb_uart_rx_fifo;
    logic clk, rst;
    logic rxd_a, rxd_b, rxd_c;
    logic rdy_a, rdy_b, rdy_c;
    logic [15:0] bd_slow, bd_fast;

    logic [7:0] d_a, d_b;
    logic [8:0] d_c;
    logic pe_a, fe_a, v_a, ov_a, busy_a;
    logic pe_b, fe_b, v_b, ov_b, busy_b;
    logic pe_c, fe_c, v_c, ov_c, busy_c;
    logic [3:0] cnt_a, cnt_b, cnt_c;

    int checks = 0;
    int failures = 0;

    uart_rx_fifo #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
        .clk(clk), .rst(rst), .baud_div(bd_slow), .rxd(rxd_a),
        .m_data(d_a), .m_parity_err(pe_a), .m_frame_err(fe_a), .m_valid(v_a),
        .m_ready(rdy_a), .overrun(ov_a), .busy(busy_a), .fifo_count(cnt_a));

    uart_rx_fifo #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_b (
        .clk(clk), .rst(rst), .baud_div(bd_slow), .rxd(rxd_b),
        .m_data(d_b), .m_parity_err(pe_b), .m_frame_err(fe_b), .m_valid(v_b),
        .m_ready(rdy_b), .overrun(ov_b), .busy(busy_b), .fifo_count(cnt_b));

    uart_rx_fifo #(.DATA_BITS(9), .PARITY(0), .STOP_BITS(2)) u_c (
        .clk(clk), .rst(rst), .baud_div(bd_fast), .rxd(rxd_c),
        .m_data(d_c), .m_parity_err(pe_c), .m_frame_err(fe_c), .m_valid(v_c),
        .m_ready(rdy_c), .overrun(ov_c), .busy(busy_c), .fifo_count(cnt_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Received words as {frame_err, parity_err, data[8:0]}
    logic [10:0] q_a[$], q_b[$], q_c[$];
    int vc_a = 0, oc_a = 0, br_a = 0, oc_b = 0, oc_c = 0;
    logic busy_a_prev = 1'b0;

    // Monitor: capture handshakes and count pulses on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            if (v_a && rdy_a) q_a.push_back({fe_a, pe_a, 1'b0, d_a});
            if (v_b && rdy_b) q_b.push_back({fe_b, pe_b, 1'b0, d_b});
            if (v_c && rdy_c) q_c.push_back({fe_c, pe_c, d_c});
            if (v_a)  vc_a <= vc_a + 1;
            if (ov_a) oc_a <= oc_a + 1;
            if (ov_b) oc_b <= oc_b + 1;
            if (ov_c) oc_c <= oc_c + 1;
            if (busy_a && !busy_a_prev) br_a <= br_a + 1;
            busy_a_prev <= busy_a;
        end
    end

    function automatic logic [10:0] mk(input logic fe, input logic pe, input logic [8:0] d);
        return {fe, pe, d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic v);
        case (sel)
            0: rxd_a = v;
            1: rxd_b = v;
            default: rxd_c = v;
        endcase
    endtask

    // Shift out n line bits, bit 0 first, one bit period each
    task automatic send(input int sel, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            drive(sel, bits[i]);
            repeat ((sel == 2) ? 16 : 64) @(negedge clk);
        end
    endtask

    task automatic idle(input int sel, input int nbits);
        send(sel, 16'hFFFF, nbits);
    endtask

    function automatic logic [15:0] fr8(input logic [7:0] d, input logic stopb);
        return {6'b0, stopb, d, 1'b0};
    endfunction

    function automatic logic [15:0] fr8p(input logic [7:0] d, input logic par);
        return {5'b0, 1'b1, par, d, 1'b0};
    endfunction

    logic [10:0] w;
    int snap_v, snap_o, snap_b;

    initial begin
        bd_slow = 16'd3;
        bd_fast = 16'd0;
        rst = 1'b1;
        rxd_a = 1'b1; rxd_b = 1'b1; rxd_c = 1'b1;
        rdy_a = 1'b0; rdy_b = 1'b0; rdy_c = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_valid", 32'(v_a), 32'd0);
        chk("rst_count", 32'(cnt_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_head", 32'({fe_a, pe_a, d_a, ov_a}), 32'd0);
        rst = 1'b0;
        idle(0, 2);

        // 8N1 0xA5 with consumer ready
        rdy_a = 1'b1;
        snap_v = vc_a; snap_o = oc_a;
        send(0, fr8(8'hA5, 1'b1), 10);
        idle(0, 1);
        chk("a5_words", 32'(q_a.size()), 32'd1);
        w = (q_a.size() > 0) ? q_a.pop_front() : 11'h7FF;
        chk("a5_word", 32'(w), 32'(mk(1'b0, 1'b0, 9'hA5)));
        chk("a5_valid_cycles", 32'(vc_a - snap_v), 32'd1);
        chk("a5_overrun", 32'(oc_a - snap_o), 32'd0);

        // Even parity on 0x03: parity bit 1 is wrong, parity bit 0 is right
        rdy_b = 1'b1;
        send(1, fr8p(8'h03, 1'b1), 11);
        idle(1, 1);
        send(1, fr8p(8'h03, 1'b0), 11);
        idle(1, 1);
        chk("par_words", 32'(q_b.size()), 32'd2);
        w = (q_b.size() > 0) ? q_b.pop_front() : 11'h7FF;
        chk("par_bad", 32'(w), 32'(mk(1'b0, 1'b1, 9'h03)));
        w = (q_b.size() > 0) ? q_b.pop_front() : 11'h7FF;
        chk("par_good", 32'(w), 32'(mk(1'b0, 1'b0, 9'h03)));

        // Stop bit low flags framing error; following frame decodes cleanly
        send(0, fr8(8'h5A, 1'b0), 10);
        idle(0, 2);
        send(0, fr8(8'hC3, 1'b1), 10);
        idle(0, 1);
        chk("fe_words", 32'(q_a.size()), 32'd2);
        w = (q_a.size() > 0) ? q_a.pop_front() : 11'h7FF;
        chk("fe_word", 32'(w), 32'(mk(1'b1, 1'b0, 9'h5A)));
        w = (q_a.size() > 0) ? q_a.pop_front() : 11'h7FF;
        chk("fe_next", 32'(w), 32'(mk(1'b0, 1'b0, 9'hC3)));

        // Short low glitch (4 ticks) is a false start
        snap_b = br_a;
        rxd_a = 1'b0;
        repeat (16) @(negedge clk);
        rxd_a = 1'b1;
        idle(0, 2);
        chk("glitch_busy_pulses", 32'(br_a - snap_b), 32'd1);
        chk("glitch_idle", 32'(busy_a), 32'd0);
        chk("glitch_count", 32'(cnt_a), 32'd0);
        chk("glitch_words", 32'(q_a.size()), 32'd0);

        // Fill past full with consumer stalled
        rdy_a = 1'b0;
        snap_o = oc_a;
        for (int i = 1; i <= 10; i++) send(0, fr8(8'(i), 1'b1), 10);
        idle(0, 1);
        chk("full_count", 32'(cnt_a), 32'd8);
        chk("full_overruns", 32'(oc_a - snap_o), 32'd2);
        rdy_a = 1'b1;
        repeat (12) @(negedge clk);
        chk("drain_words", 32'(q_a.size()), 32'd8);
        chk("drain_count", 32'(cnt_a), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            w = (q_a.size() > 0) ? q_a.pop_front() : 11'h7FF;
            chk($sformatf("drain_%0d", i), 32'(w), 32'(mk(1'b0, 1'b0, 9'(i))));
        end

        // Reset mid-DATA with line low; held low after release must not start
        rxd_a = 1'b0;
        repeat (64 * 3 + 20) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        snap_b = br_a;
        repeat (64 * 10) @(negedge clk);
        chk("rstlow_no_start", 32'(br_a - snap_b), 32'd0);
        chk("rstlow_idle", 32'(busy_a), 32'd0);
        idle(0, 1);
        send(0, fr8(8'h3C, 1'b1), 10);
        idle(0, 1);
        chk("rstlow_words", 32'(q_a.size()), 32'd1);
        w = (q_a.size() > 0) ? q_a.pop_front() : 11'h7FF;
        chk("rstlow_word", 32'(w), 32'(mk(1'b0, 1'b0, 9'h3C)));

        // 9N2 at baud_div=0, three frames back-to-back
        rdy_c = 1'b1;
        idle(2, 2);
        for (int i = 0; i < 3; i++) send(2, {4'b0, 2'b11, 9'h1FF, 1'b0}, 12);
        idle(2, 2);
        chk("b2b_words", 32'(q_c.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            w = (q_c.size() > 0) ? q_c.pop_front() : 11'h000;
            chk($sformatf("b2b_%0d", i), 32'(w), 32'(mk(1'b0, 1'b0, 9'h1FF)));
        end
        chk("no_overrun_bc", 32'(oc_b + oc_c), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
